// File: rtl/imem_sync_loadable.sv
// imem_sync_loadable: loadable instruction memory with a registered fetch port
// and a power-on clear sequence that fills every word with NOP_WORD.
module imem_sync_loadable #(
    parameter int          ADDR_W   = 8,
    parameter logic [31:0] NOP_WORD = 32'h00000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       fetch_addr,
    input  logic              fetch_req,
    input  logic              stall,
    input  logic              flush,
    output logic [31:0]       instr_out,
    output logic              instr_valid,
    output logic              fetch_fault,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data,
    output logic              busy
);
    typedef enum logic {CLEAR, RUN} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] clr_cnt, idx, wr_addr;
    logic [31:0]       mem [2**ADDR_W];
    logic [31:0]       wr_data, rd_data;
    logic              wr_en, load_fire, fault;

    assign busy       = state == CLEAR;
    assign load_ready = state == RUN;
    assign load_fire  = load_valid && load_ready;
    assign idx        = fetch_addr[ADDR_W+1:2];
    assign fault      = (|fetch_addr[1:0]) || (|fetch_addr[31:ADDR_W+2]);
    assign wr_en      = !reset && (busy || load_fire);
    assign wr_addr    = busy ? clr_cnt : load_addr;
    assign wr_data    = busy ? NOP_WORD : load_data;
    // same-cycle load to the fetched word is forwarded so the fetch sees the new data
    assign rd_data    = (load_fire && load_addr == idx) ? load_data : mem[idx];

    always_comb begin
        state_nx = state;
        if (state == CLEAR && clr_cnt == {ADDR_W{1'b1}})
            state_nx = RUN;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nx;
            clr_cnt <= busy ? clr_cnt + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset || busy || flush) begin
            instr_out   <= NOP_WORD;
            instr_valid <= 1'b0;
            fetch_fault <= 1'b0;
        end else if (!stall) begin
            instr_valid <= fetch_req;
            if (fetch_req) begin
                instr_out   <= fault ? NOP_WORD : rd_data;
                fetch_fault <= fault;
            end
        end
    end
endmodule

// File: doc/imem_sync_loadable.md
IMEM_SYNC_LOADABLE -- requirements
Module: imem_sync_loadable

Interface
REQ-001 SHALL provide parameter ADDR_W, default 8, meaning word-address width; depth = 2^ADDR_W words.
REQ-002 SHALL provide parameter NOP_WORD, default 32'h00000000, meaning the word returned for empty, flushed or faulting fetches.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 fetch_addr  input  32  byte address of the requested instruction.
REQ-007 fetch_req  input  1  fetch request, sampled at clk.
REQ-008 stall  input  1  hold the output register.
REQ-009 flush  input  1  replace the output with NOP_WORD.
REQ-010 instr_out  output  32  registered instruction.
REQ-011 instr_valid  output  1  instr_out holds a fetched word.
REQ-012 fetch_fault  output  1  the last fetch was misaligned or out of range.
REQ-013 load_valid  input  1  loader write request.
REQ-014 load_ready  output  1  loader write can be accepted.
REQ-015 load_addr  input  ADDR_W  word index to write.
REQ-016 load_data  input  32  word to write.
REQ-017 busy  output  1  clear sequence in progress.

Function
REQ-018 SHALL have two states: CLEAR and RUN.
REQ-019 CLEAR SHALL write NOP_WORD to word index clr_cnt each cycle, with clr_cnt running 0..2^ADDR_W-1.
REQ-020 CLEAR SHALL go to RUN in the cycle after index 2^ADDR_W-1 is written; a full clear takes exactly 2^ADDR_W cycles.
REQ-021 In CLEAR: busy=1, load_ready=0, fetches ignored, instr_out=NOP_WORD, instr_valid=0, fetch_fault=0.
REQ-022 In RUN: busy=0 and load_ready=1.
REQ-023 A load write SHALL occur at clk when load_valid&&load_ready, storing load_data at load_addr.
REQ-024 A fetch SHALL be accepted at clk when state=RUN && fetch_req && !stall && !flush.
REQ-025 Fetch latency SHALL be 1 cycle: the word appears on instr_out at the next edge, with instr_valid=1.
REQ-026 Word index SHALL be fetch_addr[ADDR_W+1:2].
REQ-027 Fault SHALL be fetch_addr[1:0]!=0, or any bit of fetch_addr[31:ADDR_W+2] nonzero.
REQ-028 On an accepted faulting fetch: instr_out=NOP_WORD, instr_valid=1, fetch_fault=1; the memory is not read.
REQ-029 On an accepted non-faulting fetch: fetch_fault=0.
REQ-030 A load write and fetch to the same index in one cycle SHALL return load_data (write-through bypass).
REQ-031 stall=1 (flush=0) SHALL hold instr_out, instr_valid and fetch_fault unchanged; load writes proceed.
REQ-032 flush=1 SHALL set instr_out=NOP_WORD, instr_valid=0, fetch_fault=0 at the next edge.
REQ-033 flush SHALL override stall and fetch_req.
REQ-034 In RUN with no accepted fetch, no stall and no flush, instr_valid SHALL drop to 0 and instr_out SHALL hold its value.

Reset
REQ-035 reset SHALL, at the next edge: enter CLEAR, set clr_cnt=0, instr_out=NOP_WORD, instr_valid=0, fetch_fault=0, busy=1, load_ready=0.
REQ-036 reset SHALL override every other input, including mid-CLEAR (the clear restarts from index 0) and mid-load (the in-flight write is dropped).

Verification
REQ-037 Scenario (ADDR_W=8): reset for 1 cycle -> busy=1 for exactly 256 cycles, then busy=0 and load_ready=1; fetch 0x3FC -> 0x00000000, valid=1.
REQ-038 Scenario: load idx 0 = 0x20040005 and idx 1 = 0x00001026; fetch 0x0 then 0x4 -> instr_out 0x20040005 then 0x00001026, each one cycle after request, valid=1.
REQ-039 Scenario: fetch 0x4, then stall 3 cycles while requesting 0x0 -> 0x00001026 held 4 cycles; flush -> 0x00000000, valid=0.
REQ-040 Scenario: fetch 0x400 -> NOP, valid=1, fault=1; fetch 0x2 -> fault=1; fetch 0x8 -> fault=0.
REQ-041 Scenario: same cycle, load idx 5 = 0xDEADBEEF and fetch 0x14 -> next-cycle instr_out=0xDEADBEEF.
REQ-042 Scenario: reset asserted at clear cycle 100 -> busy stays 1 for 256 further cycles; word at idx 0 previously loaded reads 0x00000000.
